// File: rtl/imem_stream_loader.sv
// imem_stream_loader: receives a framed byte stream (4-byte little-endian
// word count, payload words, one checksum byte) and writes each assembled
// word into instruction memory. When the frame checks out it releases the
// core through loader_done; otherwise it raises load_err.
module imem_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        loader_done,
  output logic        load_err,
  output logic [15:0] words_written
);

  localparam logic [2:0] S_HDR  = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic [23:0] shift_reg;
  logic [31:0] word_count;
  logic [1:0]  byte_idx;
  logic        hdr_started;
  logic [7:0]  csum;
  logic [31:0] timer;

  logic        accept;
  logic        last_byte;
  logic [31:0] assembled;
  logic        timing;
  logic        timed_out;
  logic        do_restart;
  logic        next_active;

  // Handshake, word assembly and timeout qualification. The timer only runs
  // once a frame has begun, so an idle loader waiting for a header never errors.
  always_comb begin
    accept      = byte_valid & byte_ready;
    last_byte   = (byte_idx == 2'd3);
    assembled   = {byte_data, shift_reg};
    timing      = ((state == S_HDR) && hdr_started) || (state == S_LOAD) || (state == S_CHK);
    timed_out   = timing && !accept && (timer == 32'(TIMEOUT - 1));
    do_restart  = restart && ((state == S_DONE) || (state == S_ERR));
    next_active = (next_state == S_HDR) || (next_state == S_LOAD) || (next_state == S_CHK);
  end

  // Frame sequencing: header, payload, checksum, then an absorbing end state.
  always_comb begin
    next_state = state;
    case (state)
      S_HDR: begin
        if (accept && last_byte) begin
          if (assembled == 32'd0)
            next_state = S_CHK;
          else if (assembled > 32'(MAX_WORDS))
            next_state = S_ERR;
          else
            next_state = S_LOAD;
        end else if (timed_out) begin
          next_state = S_ERR;
        end
      end
      S_LOAD: begin
        if (accept && last_byte && (({16'd0, words_written} + 32'd1) == word_count))
          next_state = S_CHK;
        else if (timed_out)
          next_state = S_ERR;
      end
      S_CHK: begin
        if (accept)
          next_state = ((csum ^ byte_data) == 8'h00) ? S_DONE : S_ERR;
        else if (timed_out)
          next_state = S_ERR;
      end
      S_DONE, S_ERR: begin
        if (restart)
          next_state = S_HDR;
      end
      default: next_state = S_HDR;
    endcase
  end

  // Registered datapath: byte collection, write strobe, checksum, timer and
  // sticky status flags. byte_ready is registered from the next state so it
  // stays low during reset and rises on the first clock afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_HDR;
      byte_ready    <= 1'b0;
      shift_reg     <= 24'd0;
      word_count    <= 32'd0;
      byte_idx      <= 2'd0;
      hdr_started   <= 1'b0;
      csum          <= 8'h00;
      timer         <= 32'd0;
      imem_we       <= 1'b0;
      imem_waddr    <= BASE_ADDR;
      imem_wdata    <= 32'd0;
      loader_done   <= 1'b0;
      load_err      <= 1'b0;
      words_written <= 16'd0;
    end else begin
      state      <= next_state;
      byte_ready <= next_active;
      imem_we    <= 1'b0;
      if (do_restart) begin
        shift_reg     <= 24'd0;
        word_count    <= 32'd0;
        byte_idx      <= 2'd0;
        hdr_started   <= 1'b0;
        csum          <= 8'h00;
        timer         <= 32'd0;
        imem_waddr    <= BASE_ADDR;
        loader_done   <= 1'b0;
        load_err      <= 1'b0;
        words_written <= 16'd0;
      end else begin
        if (accept) begin
          csum      <= csum ^ byte_data;
          shift_reg <= assembled[31:8];
          byte_idx  <= byte_idx + 2'd1;
          timer     <= 32'd0;
          if (state == S_HDR) begin
            hdr_started <= 1'b1;
            if (last_byte)
              word_count <= assembled;
          end
          if ((state == S_LOAD) && last_byte) begin
            imem_we       <= 1'b1;
            imem_wdata    <= assembled;
            imem_waddr    <= BASE_ADDR + {14'd0, words_written, 2'b00};
            words_written <= words_written + 16'd1;
          end
        end else if (timing) begin
          timer <= timer + 32'd1;
        end
        if ((state == S_CHK) && (next_state == S_DONE))
          loader_done <= 1'b1;
        if ((state != S_ERR) && (next_state == S_ERR))
          load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: frame tasks push the expected
// imem writes into a queue, and an independent monitor pops and compares
// every write strobe the loader produces.
module tb_imem_stream_loader;

  localparam int TIMEOUT = 1024;

  logic        clk;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        restart;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        loader_done;
  logic        load_err;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [7:0]  run_csum;
  int          exp_idx;
  int          max_gap;

  imem_stream_loader dut (
    .clk(clk),
    .rst(rst),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .restart(restart),
    .imem_we(imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .loader_done(loader_done),
    .load_err(load_err),
    .words_written(words_written)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL imem_write unexpected addr=%h data=%h, required no write", imem_waddr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({imem_waddr, imem_wdata} !== e) begin
          errors++;
          $display("[TB] FAIL imem_write addr=%h data=%h, required addr=%h data=%h",
                   imem_waddr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  // Compare one observed value against a bench-supplied expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Present one byte at a negedge and hold it until the loader takes it.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_handshake actual=ready_low required=ready_within_100_cycles");
    end
    @(posedge clk);
    @(negedge clk);
    run_csum = run_csum ^ b;
    if (max_gap > 0) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendHeader(input logic [31:0] n);
    run_csum = 8'h00;
    exp_idx  = 0;
    for (int i = 0; i < 4; i++) applyStimulus(n[8*i +: 8]);
  endtask

  task automatic sendWord(input logic [31:0] w);
    exp_q.push_back({32'(exp_idx * 4), w});
    exp_idx++;
    for (int i = 0; i < 4; i++) applyStimulus(w[8*i +: 8]);
  endtask

  task automatic sendChecksum(input logic [7:0] flip);
    applyStimulus(run_csum ^ flip);
    byte_valid = 1'b0;
  endtask

  task automatic doRestart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checkOutput("restart_done", {31'd0, loader_done}, 32'd0);
    checkOutput("restart_err", {31'd0, load_err}, 32'd0);
    checkOutput("restart_words", {16'd0, words_written}, 32'd0);
    checkOutput("restart_waddr", imem_waddr, 32'h0);
    checkOutput("restart_ready", {31'd0, byte_ready}, 32'd1);
  endtask

  task automatic sendProgram();
    sendHeader(32'd4);
    sendWord(32'h0050_0093);
    sendWord(32'h00A0_0113);
    sendWord(32'h0020_81B3);
    sendWord(32'h0000_006F);
  endtask

  // Directed test sequence.
  initial begin
    int waited;
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    restart    = 1'b0;
    max_gap    = 0;
    run_csum   = 8'h00;
    exp_idx    = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("reset_we", {31'd0, imem_we}, 32'd0);
    checkOutput("reset_waddr", imem_waddr, 32'h0);
    checkOutput("reset_wdata", imem_wdata, 32'h0);
    checkOutput("reset_done", {31'd0, loader_done}, 32'd0);
    checkOutput("reset_err", {31'd0, load_err}, 32'd0);
    checkOutput("reset_words", {16'd0, words_written}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'd0, byte_ready}, 32'd1);

    $display("[TB] good frame back-to-back");
    sendProgram();
    sendChecksum(8'h00);
    checkOutput("good_done", {31'd0, loader_done}, 32'd1);
    checkOutput("good_err", {31'd0, load_err}, 32'd0);
    checkOutput("good_words", {16'd0, words_written}, 32'd4);
    checkOutput("good_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("good_queue", 32'(exp_q.size()), 32'd0);
    idle(3);
    doRestart();

    $display("[TB] bad checksum");
    sendProgram();
    sendChecksum(8'h01);
    idle(1);
    checkOutput("badsum_err", {31'd0, load_err}, 32'd1);
    checkOutput("badsum_done", {31'd0, loader_done}, 32'd0);
    checkOutput("badsum_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("badsum_words", {16'd0, words_written}, 32'd4);
    checkOutput("badsum_queue", 32'(exp_q.size()), 32'd0);
    doRestart();

    $display("[TB] oversize header");
    sendHeader(32'd257);
    byte_valid = 1'b0;
    checkOutput("oversize_err", {31'd0, load_err}, 32'd1);
    checkOutput("oversize_ready", {31'd0, byte_ready}, 32'd0);
    idle(4);
    checkOutput("oversize_words", {16'd0, words_written}, 32'd0);
    doRestart();

    $display("[TB] empty frame");
    sendHeader(32'd0);
    sendChecksum(8'h00);
    checkOutput("empty_done", {31'd0, loader_done}, 32'd1);
    checkOutput("empty_words", {16'd0, words_written}, 32'd0);
    doRestart();

    $display("[TB] timeout after 6 bytes");
    sendHeader(32'd4);
    applyStimulus(8'h93);
    applyStimulus(8'h00);
    byte_valid = 1'b0;
    waited = 0;
    while (!load_err && waited < TIMEOUT + 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("timeout_err", {31'd0, load_err}, 32'd1);
    checkOutput("timeout_cycles", 32'(waited), 32'(TIMEOUT));
    checkOutput("timeout_words", {16'd0, words_written}, 32'd0);
    doRestart();

    $display("[TB] reset mid-frame");
    sendHeader(32'd4);
    sendWord(32'h1111_2222);
    sendWord(32'h3333_4444);
    idle(1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'd0, byte_ready}, 32'd0);
    checkOutput("midrst_we", {31'd0, imem_we}, 32'd0);
    checkOutput("midrst_waddr", imem_waddr, 32'h0);
    checkOutput("midrst_wdata", imem_wdata, 32'h0);
    checkOutput("midrst_words", {16'd0, words_written}, 32'd0);
    checkOutput("midrst_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    $display("[TB] error then restart with one-word frame");
    sendHeader(32'd300);
    byte_valid = 1'b0;
    checkOutput("pre_restart_err", {31'd0, load_err}, 32'd1);
    doRestart();
    sendHeader(32'd1);
    sendWord(32'hDEAD_BEEF);
    sendChecksum(8'h00);
    checkOutput("one_done", {31'd0, loader_done}, 32'd1);
    checkOutput("one_words", {16'd0, words_written}, 32'd1);
    checkOutput("one_waddr", imem_waddr, 32'h0);
    doRestart();

    $display("[TB] good frame with random gaps");
    max_gap = 7;
    sendProgram();
    sendChecksum(8'h00);
    max_gap = 0;
    idle(1);
    checkOutput("gap_done", {31'd0, loader_done}, 32'd1);
    checkOutput("gap_err", {31'd0, load_err}, 32'd0);
    checkOutput("gap_words", {16'd0, words_written}, 32'd4);
    idle(3);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
